// File: rtl/fpu_add_arbiter.sv
// fpu_add_arbiter: shares one FP adder among NREQ requesters, round-robin by default or fixed priority with FPU_ARB_FIXED_PRIO_EN
module fpu_add_arbiter #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ*32-1:0] rq_a,
  input  logic [NREQ*32-1:0] rq_b,
  input  logic [NREQ-1:0]   rq_stb,
  output logic [NREQ-1:0]   rq_ack,
  output logic [31:0]       rz,
  output logic [NREQ-1:0]   rz_stb,
  input  logic [NREQ-1:0]   rz_ack,
  output logic [31:0]       fpu_a,
  output logic [31:0]       fpu_b,
  output logic              fpu_a_stb,
  output logic              fpu_b_stb,
  input  logic              fpu_a_ack,
  input  logic              fpu_b_ack,
  input  logic [31:0]       fpu_z,
  input  logic              fpu_z_stb,
  output logic              fpu_z_ack,
  output logic              busy
);
  localparam int GW = $clog2(NREQ);
  typedef enum logic [2:0] {IDLE, ACCEPT, SEND_A, SEND_B, WAIT_Z, PUT_Z} state_t;
  state_t state;
  logic [GW-1:0] g, nxt;
  logic hit;
`ifdef FPU_ARB_FIXED_PRIO_EN
  // lowest-index pending requester wins
  always_comb begin
    nxt = '0;
    hit = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (rq_stb[i]) begin
        nxt = GW'(i);
        hit = 1'b1;
      end
  end
`else
  logic [GW-1:0] last;
  // first pending requester after the last one served, scanning circularly
  always_comb begin
    nxt = '0;
    hit = 1'b0;
    for (int k = NREQ; k >= 1; k--)
      if (rq_stb[(int'(last) + k) % NREQ]) begin
        nxt = GW'((int'(last) + k) % NREQ);
        hit = 1'b1;
      end
  end
`endif
  assign busy = state != IDLE;
  // operation sequencer: accept operands, feed adder A then B, collect Z, hand result back
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      g         <= '0;
      rq_ack    <= '0;
      rz_stb    <= '0;
      fpu_a_stb <= 1'b0;
      fpu_b_stb <= 1'b0;
      fpu_z_ack <= 1'b0;
      rz        <= '0;
      fpu_a     <= '0;
      fpu_b     <= '0;
`ifndef FPU_ARB_FIXED_PRIO_EN
      last      <= GW'(NREQ - 1);
`endif
    end else begin
      case (state)
        IDLE:
          if (hit) begin
            g      <= nxt;
            rq_ack <= NREQ'(1) << nxt;
            state  <= ACCEPT;
          end
        ACCEPT:
          if (rq_stb[g] && rq_ack[g]) begin
            fpu_a     <= rq_a[32*g +: 32];
            fpu_b     <= rq_b[32*g +: 32];
            rq_ack    <= '0;
            fpu_a_stb <= 1'b1;
            state     <= SEND_A;
          end
        SEND_A:
          if (fpu_a_ack) begin
            fpu_a_stb <= 1'b0;
            fpu_b_stb <= 1'b1;
            state     <= SEND_B;
          end
        SEND_B:
          if (fpu_b_ack) begin
            fpu_b_stb <= 1'b0;
            fpu_z_ack <= 1'b1;
            state     <= WAIT_Z;
          end
        WAIT_Z:
          if (fpu_z_stb) begin
            rz        <= fpu_z;
            fpu_z_ack <= 1'b0;
            rz_stb    <= NREQ'(1) << g;
            state     <= PUT_Z;
          end
        PUT_Z:
          if (rz_ack[g]) begin
            rz_stb <= '0;
`ifndef FPU_ARB_FIXED_PRIO_EN
            last   <= g;
`endif
            state  <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_add_arbiter.sv
// tb_fpu_add_arbiter: randomized bench with requester, adder and scoreboard models
module tb_fpu_add_arbiter;
  localparam int NREQ = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ*32-1:0] rq_a = '0, rq_b = '0;
  logic [NREQ-1:0] rq_stb = '0, rq_ack, rz_stb, rz_ack = '0;
  logic [31:0] rz, fpu_a, fpu_b, fpu_z = '0;
  logic fpu_a_stb, fpu_b_stb, fpu_a_ack = 1'b0, fpu_b_ack = 1'b0, fpu_z_stb = 1'b0, fpu_z_ack, busy;

  fpu_add_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .rq_a(rq_a), .rq_b(rq_b), .rq_stb(rq_stb), .rq_ack(rq_ack),
    .rz(rz), .rz_stb(rz_stb), .rz_ack(rz_ack), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_a_stb(fpu_a_stb), .fpu_b_stb(fpu_b_stb), .fpu_a_ack(fpu_a_ack), .fpu_b_ack(fpu_b_ack),
    .fpu_z(fpu_z), .fpu_z_stb(fpu_z_stb), .fpu_z_ack(fpu_z_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [31:0] ra[NREQ], rb[NREQ];
  logic [31:0] exp_q[NREQ][$], opa_q[NREQ][$], opb_q[NREQ][$];
  int glog[$], dl_i[$];
  logic [31:0] dl_z[$];
  int rem[NREQ];
  int hold = 0, nbp = 0, ndone = 0, last_ref = NREQ - 1, zdly = 0;
  logic hold_en = 1'b0, cont = 1'b0, z_hold = 1'b0, rst_next = 1'b1;
  logic got_a = 1'b0, got_b = 1'b0, zpend = 1'b0, chk_fa = 1'b0;
  logic [31:0] fa, fb, exp_fa, held_rz, ax_d, bx_d, rz_d;
  logic [NREQ-1:0] rqx = '0, rzx = '0, prev_stb = '0, prev_ack = '0;
  logic ax = 1'b0, bx = 1'b0, zx = 1'b0, rst_d = 1'b1, prev_busy = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] x);
    if (x[30:23] == 8'd0) return $bitstoreal({x[31], 63'd0});
    return $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rndf();
    int v;
    v = int'($urandom_range(200)) - 100;
    return r2f(real'(v));
  endfunction

  function automatic int exp_grant(input logic [NREQ-1:0] s, input int lst);
`ifdef FPU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (s[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (s[(lst + k) % NREQ]) return (lst + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic tick();
    int w;
    @(negedge clk);
    chk_fa = 1'b0;
    if (rst_d) begin
      got_a = 1'b0;
      got_b = 1'b0;
      zpend = 1'b0;
      fpu_z_stb = 1'b0;
      last_ref = NREQ - 1;
      for (int i = 0; i < NREQ; i++) exp_q[i].delete();
    end else begin
      if (ax) begin got_a = 1'b1; fa = ax_d; end
      if (bx) begin got_b = 1'b1; fb = bx_d; end
      if (zx) begin zpend = 1'b0; fpu_z_stb = 1'b0; end
      for (int i = 0; i < NREQ; i++)
        if (rqx[i]) begin
          exp_q[i].push_back(fadd(ra[i], rb[i]));
          exp_fa = ra[i];
          chk_fa = 1'b1;
          glog.push_back(i);
          rq_stb[i] = 1'b0;
        end
      for (int i = 0; i < NREQ; i++)
        if (rzx[i]) begin
          last_ref = i;
          dl_i.push_back(i);
          dl_z.push_back(rz_d);
          if (exp_q[i].size() != 0) void'(exp_q[i].pop_front());
          ndone++;
        end
    end
    if (chk_fa) begin
      chk("fpu_a_stb_after_accept", 32'(fpu_a_stb), 32'd1);
      chk("fpu_a_operand", fpu_a, exp_fa);
    end
    if (!rst_d && !prev_busy && prev_stb != '0) chk("ack_latency", 32'(rq_ack != '0), 32'd1);
    if (!rst_d && prev_ack == '0 && rq_ack != '0) begin
      w = exp_grant(prev_stb, last_ref);
      chk("grant", 32'(rq_ack), w < 0 ? 32'd0 : 32'd1 << w);
    end
    if (rz_stb != '0) begin
      w = 0;
      for (int i = NREQ - 1; i >= 0; i--) if (rz_stb[i]) w = i;
      chk("rz_stb_onehot", 32'($onehot(rz_stb)), 32'd1);
      chk("rz_stb_expected", 32'(exp_q[w].size() != 0), 32'd1);
      if (exp_q[w].size() != 0) chk("rz_value", rz, exp_q[w][0]);
      chk("no_grant_during_put", 32'(rq_ack), 32'd0);
    end
    if (hold > 0) begin
      nbp++;
      chk("bp_rz_stb", 32'(rz_stb[0]), 32'd1);
      chk("bp_rz_stable", rz, held_rz);
      chk("bp_rq_ack", 32'(rq_ack), 32'd0);
    end
    rst = rst_next;
    if (got_a && got_b && !zpend && !z_hold) begin
      if (zdly == 0) begin
        fpu_z = fadd(fa, fb);
        fpu_z_stb = 1'b1;
        zpend = 1'b1;
        got_a = 1'b0;
        got_b = 1'b0;
        zdly = int'($urandom_range(3));
      end else zdly--;
    end
    fpu_a_ack = !got_a && !got_b && !zpend && ($urandom_range(3) != 0);
    fpu_b_ack = got_a && !got_b && ($urandom_range(3) != 0);
    for (int i = 0; i < NREQ; i++) begin
      if (!rq_stb[i] && rem[i] > 0 && (cont || $urandom_range(2) == 0)) begin
        ra[i] = opa_q[i].size() != 0 ? opa_q[i].pop_front() : rndf();
        rb[i] = opb_q[i].size() != 0 ? opb_q[i].pop_front() : rndf();
        rq_stb[i] = 1'b1;
        rem[i]--;
      end
      rq_a[32*i +: 32] = ra[i];
      rq_b[32*i +: 32] = rb[i];
    end
    if (hold > 0) hold--;
    if (hold_en && rz_stb[0] && hold == 0) begin
      hold = 5;
      held_rz = rz;
      hold_en = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) rz_ack[i] = (i == 0 && hold > 0) ? 1'b0 : ($urandom_range(3) != 0);
    rqx = rq_stb & rq_ack;
    rzx = rz_stb & rz_ack;
    ax = fpu_a_stb && fpu_a_ack;
    bx = fpu_b_stb && fpu_b_ack;
    zx = fpu_z_stb && fpu_z_ack;
    ax_d = fpu_a;
    bx_d = fpu_b;
    rz_d = rz;
    rst_d = rst;
    prev_stb = rq_stb;
    prev_ack = rq_ack;
    prev_busy = busy;
  endtask

  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (ndone < target && n < budget) begin
      tick();
      n++;
    end
    chk("complete", 32'(ndone >= target), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rq_ack"}, 32'(rq_ack), 32'd0);
    chk({tag, "_rz_stb"}, 32'(rz_stb), 32'd0);
    chk({tag, "_fpu_a_stb"}, 32'(fpu_a_stb), 32'd0);
    chk({tag, "_fpu_b_stb"}, 32'(fpu_b_stb), 32'd0);
    chk({tag, "_fpu_z_ack"}, 32'(fpu_z_ack), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rz"}, rz, 32'd0);
    chk({tag, "_fpu_a"}, fpu_a, 32'd0);
    chk({tag, "_fpu_b"}, fpu_b, 32'd0);
  endtask

  task automatic reset_dut();
    rst_next = 1'b1;
    repeat (3) tick();
    rst_next = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0;
      ra[i] = '0;
      rb[i] = '0;
    end
    reset_dut();
    check_reset_outputs("reset");
    opa_q[0].push_back(32'h3F800000);
    opb_q[0].push_back(32'h40000000);
    rem[0] = 1;
    dl_i.delete();
    dl_z.delete();
    run_until(ndone + 1, 300);
    chk("single_count", dl_z.size(), 32'd1);
    if (dl_z.size() > 0) begin
      chk("single_who", dl_i[0], 32'd0);
      chk("single_rz", dl_z[0], 32'h40400000);
    end
    reset_dut();
    cont = 1'b1;
    opa_q[0].push_back(32'h40400000);
    opb_q[0].push_back(32'h3F800000);
    opa_q[1].push_back(32'h3F800000);
    opb_q[1].push_back(32'hBF800000);
    rem[0] = 1;
    rem[1] = 1;
    dl_i.delete();
    dl_z.delete();
    run_until(ndone + 2, 300);
    chk("simul_count", dl_z.size(), 32'd2);
    if (dl_z.size() > 1) begin
      chk("simul_first_who", dl_i[0], 32'd0);
      chk("simul_first_rz", dl_z[0], 32'h40800000);
      chk("simul_second_who", dl_i[1], 32'd1);
      chk("simul_second_rz", dl_z[1], 32'h00000000);
    end
    glog.delete();
`ifdef FPU_ARB_FIXED_PRIO_EN
    rem[0] = 6;
    rem[1] = 1;
    run_until(ndone + 7, 1000);
    chk("cont_grants", glog.size(), 32'd7);
    for (int k = 0; k < 6 && k < glog.size(); k++) chk("cont_order", glog[k], 32'd0);
`else
    rem[0] = 3;
    rem[1] = 3;
    run_until(ndone + 6, 1000);
    chk("cont_grants", glog.size(), 32'd6);
    for (int k = 0; k < 6 && k < glog.size(); k++) chk("cont_order", glog[k], k % 2);
`endif
    rem[0] = 1;
    rem[1] = 1;
    hold_en = 1'b1;
    nbp = 0;
    run_until(ndone + 2, 400);
    chk("bp_cycles", nbp, 32'd5);
    z_hold = 1'b1;
    rem[0] = 1;
    for (int n = 0; n < 200 && !fpu_z_ack; n++) tick();
    chk("reached_wait_z", 32'(fpu_z_ack), 32'd1);
    rst_next = 1'b1;
    tick();
    rst_next = 1'b0;
    tick();
    check_reset_outputs("midop_reset");
    z_hold = 1'b0;
    repeat (20) tick();
    opa_q[0].push_back(32'h3F800000);
    opb_q[0].push_back(32'h3F800000);
    rem[0] = 1;
    dl_i.delete();
    dl_z.delete();
    run_until(ndone + 1, 300);
    chk("post_reset_count", dl_z.size(), 32'd1);
    if (dl_z.size() > 0) chk("post_reset_rz", dl_z[0], 32'h40000000);
    cont = 1'b0;
    rem[0] = 25;
    rem[1] = 25;
    run_until(ndone + 50, 8000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpu_add_arbiter.md
# fpu_add_arbiter

Round-robin arbiter that shares one single-precision floating-point adder (`adder_fpu`) between `NREQ` requesters. Each requester offers an operand pair and receives its sum over strobe/ack handshakes. The arbiter sequences the adder's three handshakes (operand A, operand B, result Z) on behalf of the granted requester. It sits between client engines (coprocessor command decoder, encrypt-side scaling logic) and the shared adder instance.

## Interface
- `NREQ`, 2, number of requesters; legal range 2..8.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high. Must also drive the adder's `rst`.
- `rq_a`  in  NREQ*32  operand A per requester; slice i = `[32*i+31:32*i]`.
- `rq_b`  in  NREQ*32  operand B per requester; same slicing.
- `rq_stb`  in  NREQ  request strobe per requester.
- `rq_ack`  out  NREQ  request accept, one-hot or zero.
- `rz`  out  32  result data, shared by all requesters.
- `rz_stb`  out  NREQ  result strobe, one-hot or zero.
- `rz_ack`  in  NREQ  result accept per requester.
- `fpu_a`, `fpu_b`  out  32 each  to adder `input_a` / `input_b`.
- `fpu_a_stb`, `fpu_b_stb`  out  1 each  to adder `input_a_stb` / `input_b_stb`.
- `fpu_a_ack`, `fpu_b_ack`  in  1 each  from adder `input_a_ack` / `input_b_ack`.
- `fpu_z`  in  32  from adder `output_z`.
- `fpu_z_stb`  in  1  from adder `output_z_stb`.
- `fpu_z_ack`  out  1  to adder `output_z_ack`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Handshake rule (all ports):**
  - A transfer occurs on a rising edge where stb and ack are both high.
  - The producer holds stb and data stable from assertion until the transfer.
  - Requesters must not drop `rq_stb` before `rq_ack`.
- **FSM states:** IDLE, ACCEPT, SEND_A, SEND_B, WAIT_Z, PUT_Z.
- **IDLE:**
  - If any `rq_stb` is high, register grant `g` and go to ACCEPT.
  - `g` is the first requester with `rq_stb` high, scanning circularly from `last+1`.
  - Otherwise stay in IDLE.
- **ACCEPT:**
  - Drive `rq_ack[g]`=1.
  - On transfer: latch `rq_a` slice g into `op_a` and `rq_b` slice g into `op_b`, drop ack, go to SEND_A.
- **SEND_A:** drive `fpu_a_stb`=1 and `fpu_a`=`op_a`. On `fpu_a_stb && fpu_a_ack`, drop stb and go to SEND_B.
- **SEND_B:** same as SEND_A using `fpu_b`, then go to WAIT_Z.
- **WAIT_Z:** drive `fpu_z_ack`=1. On `fpu_z_stb && fpu_z_ack`, latch `fpu_z` into `res`, drop ack, go to PUT_Z.
- **PUT_Z:**
  - Drive `rz_stb[g]`=1 and `rz`=`res`.
  - On transfer: drop stb, set `last`=`g`, go to IDLE.
- Exactly one operation is in flight; there is no queueing. Non-granted requesters simply wait with stb held.
- `rz` holds its last value outside PUT_Z. `fpu_a`/`fpu_b` hold `op_a`/`op_b`.
- No arithmetic is performed in this block; results are passed bit-exact from the adder, including NaN, inf and −0.

## Timing
- **Reset:**
  - State = IDLE and `last` = NREQ−1, so requester 0 wins first.
  - `rq_ack`, `rz_stb`, `fpu_a_stb`, `fpu_b_stb`, `fpu_z_ack`, `busy` = 0.
  - `rz`, `fpu_a`, `fpu_b` = 0.
- **Reset mid-operation:**
  - On the cycle after `rst` high, all outputs take their reset values regardless of state.
  - The in-flight operation is discarded; no result is delivered.
  - The adder is reset by the same `rst`.
- **Latency:**
  - `rq_stb` rising in IDLE → `rq_ack` high 1 cycle later.
  - Transfer → `fpu_a_stb` high on the next cycle.
  - Arbiter overhead per operation, excluding adder cycles and requester stalls: 6 cycles.
- **Grant timing:**
  - Grant is decided only in IDLE. Requests arriving in any other state wait.
  - Simultaneous requests resolve by the round-robin pointer in the same IDLE cycle.
- **Result backpressure:** `rz_ack` held low keeps PUT_Z indefinitely, with `rz` stable; no new grant is made.
- **Pointer wrap:** requester NREQ−1 is followed by requester 0.
- **Adder stall:** `fpu_a_ack` or `fpu_z_stb` low for any duration is legal; the arbiter waits with no timeout.

## Configuration
- `FPU_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. The lowest-index requester with `rq_stb` high is always granted, and `last` is unused.
  - Undefined (default): round-robin as specified above.

## Test plan
- **Single request:** req0 `rq_a`=0x3F800000, `rq_b`=0x40000000.
  - Expect `rz_stb[0]` with `rz`=0x40400000.
  - Expect `rq_ack[1]` and `rz_stb[1]` never asserted.
- **Simultaneous requests after reset:** req0 (0x40400000 + 0x3F800000) and req1 (0x3F800000 + 0xBF800000).
  - Expect req0 served first with 0x40800000, then req1 with 0x00000000.
- **Continuous requests:** both requesters hold `rq_stb` for 6 operations.
  - Expect grant order 0,1,0,1,0,1.
  - With `FPU_ARB_FIXED_PRIO_EN` defined: expect 0,0,0,0,0,0.
- **Result backpressure:** `rz_ack[0]` held low for 5 cycles.
  - Expect `rz_stb[0]`=1 and `rz` stable throughout.
  - Expect `rq_ack` to stay 0 even though req1 is pending.
- **Reset in WAIT_Z:** assert `rst` for 1 cycle during WAIT_Z.
  - Expect all outputs zero and `busy`=0 the next cycle.
  - Expect no `rz_stb` for the aborted operation.
  - Expect the next request to complete normally.
